// File: rtl/midi_tx_encoder_if.sv
// Byte handshake between the MIDI transmit encoder and the UART transmitter.
// A byte transfers on a clock edge where tx_valid and tx_ready are both high.
interface midi_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/midi_tx_encoder.sv
// MIDI transmit encoder: queues note/controller events and serialises them into
// MIDI message bytes over a valid/ready byte handshake, with optional running status.
module midi_tx_encoder #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter bit          RUNNING_STATUS = 1'b1
) (
    input  logic        clk96,
    input  logic        rst,
    input  logic        note_on,
    input  logic        note_off,
    input  logic        key_pressure,
    input  logic        pitch_bend,
    input  logic [3:0]  channel,
    input  logic [6:0]  note,
    input  logic [6:0]  velocity,
    input  logic [13:0] bend,
    midi_tx_if.master   tx,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StStatus, StData1, StData2} state_e;

    // Entry layout: {type[1:0], channel[3:0], d1[6:0], d2[6:0]}
    logic [3:0]  pulses;
    logic        ev_valid;
    logic        ev_collide;
    logic [1:0]  ev_type;
    logic [6:0]  ev_d1;
    logic [6:0]  ev_d2;
    logic [19:0] ev_entry;

    logic [19:0]   fifo_q [FIFO_DEPTH];
    logic [PtrW:0] wr_ptr_q;
    logic [PtrW:0] rd_ptr_q;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [19:0]   head;
    logic [7:0]    head_status;
    logic          overflow_q;

    state_e      state_q;
    logic [13:0] msg_q;
    logic [7:0]  status_q;
    logic [7:0]  last_status_q;
    logic [7:0]  tx_data_q;
    logic        tx_valid_q;

    assign pulses = {pitch_bend, key_pressure, note_on, note_off};

    always_comb begin
        ev_valid   = |pulses;
        ev_collide = (pulses & (pulses - 4'd1)) != 4'd0;
        ev_type    = 2'd3;
        if (note_off) begin
            ev_type = 2'd0;
        end else if (note_on) begin
            ev_type = 2'd1;
        end else if (key_pressure) begin
            ev_type = 2'd2;
        end
        ev_d1    = (ev_type == 2'd3) ? bend[6:0]  : note;
        ev_d2    = (ev_type == 2'd3) ? bend[13:7] : velocity;
        ev_entry = {ev_type, channel, ev_d1, ev_d2};
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop        = (state_q == StIdle) && !fifo_empty;
    // A pop in the same edge frees the slot the write needs.
    assign push       = ev_valid && (!fifo_full || pop);
    assign head       = fifo_q[rd_ptr_q[PtrW-1:0]];

    // Type codes 0..2 map to 0x8/0x9/0xA; pitch bend is 0xE.
    assign head_status = {1'b1, (head[19:18] == 2'd3) ? 3'b110 : {1'b0, head[19:18]},
                          head[17:14]};

    always_ff @(posedge clk96) begin
        if (push) begin
            fifo_q[wr_ptr_q[PtrW-1:0]] <= ev_entry;
        end
    end

    always_ff @(posedge clk96) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            overflow_q <= overflow_q | ev_collide | (ev_valid && !push);
        end
    end

    // Each byte state first presents its byte, then advances on the handshake while
    // loading the following byte so consecutive bytes of a message go out back to back.
    always_ff @(posedge clk96) begin
        if (rst) begin
            state_q       <= StIdle;
            msg_q         <= '0;
            status_q      <= 8'h00;
            last_status_q <= 8'h00;
            tx_data_q     <= 8'h00;
            tx_valid_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        msg_q    <= head[13:0];
                        status_q <= head_status;
                        if (RUNNING_STATUS && (head_status == last_status_q)) begin
                            state_q <= StData1;
                        end else begin
                            state_q <= StStatus;
                        end
                    end
                end
                StStatus: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= status_q;
                    end else if (tx.tx_ready) begin
                        last_status_q <= status_q;
                        tx_data_q     <= {1'b0, msg_q[13:7]};
                        state_q       <= StData1;
                    end
                end
                StData1: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= {1'b0, msg_q[13:7]};
                    end else if (tx.tx_ready) begin
                        tx_data_q <= {1'b0, msg_q[6:0]};
                        state_q   <= StData2;
                    end
                end
                StData2: begin
                    if (!tx_valid_q) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= {1'b0, msg_q[6:0]};
                    end else if (tx.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx.tx_data  = tx_data_q;
    assign tx.tx_valid = tx_valid_q;
    assign busy        = !fifo_empty || (state_q != StIdle);
    assign overflow    = overflow_q;

endmodule
